// File: rtl/ocd_stream_loader.sv
// Byte-stream image loader: parses ENTRY and load segments, drives OCD word writes, then starts the MCU.
// Optional macro LOADER_CHECKSUM_EN adds a trailing two's-complement checksum byte after the terminator.
module ocd_stream_loader #(
    parameter int XLEN          = 32,
    parameter int MEM_ADDR_BITS = 16,
    parameter int MAX_SEGMENTS  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [7:0]                        in_data,
    output logic                              ocd_write_enable,
    output logic [MEM_ADDR_BITS-1:0]          ocd_rw_addr,
    output logic [XLEN-1:0]                   ocd_write_word,
    output logic                              start,
    output logic [XLEN-1:0]                   start_address,
    output logic                              load_done,
    output logic                              load_error,
    output logic [$clog2(MAX_SEGMENTS+1)-1:0] seg_count
);
    localparam int L   = XLEN / 8;
    localparam int LB  = $clog2(L);
    localparam int CW  = LB + 1;
    localparam int SCW = $clog2(MAX_SEGMENTS + 1);

    typedef enum logic [3:0] {
        S_ENTRY,
        S_SEG_ADDR,
        S_SEG_SIZE,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_START,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            byte_cnt_q, byte_cnt_d;
    logic [XLEN-1:0]          word_q, word_d;
    logic [XLEN-1:0]          entry_q, entry_d;
    logic [MEM_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [XLEN-1:0]          remain_q, remain_d;
    logic [SCW-1:0]           seg_q, seg_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [XLEN-1:0]          wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               sum_q, sum_d;
`endif

    logic            accept;
    logic            field_done;
    logic [XLEN-1:0] field_word;
    logic            low_bits_set;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        entry_d    = entry_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        seg_d      = seg_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        unique case (state_q)
            S_ENTRY, S_SEG_ADDR, S_SEG_SIZE, S_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                                 in_ready = 1'b1;
`endif
            default:                                 in_ready = 1'b0;
        endcase

        accept       = in_valid && in_ready;
        field_done   = accept && (byte_cnt_q == CW'(L - 1));
        // Byte k of a field lands in bits [8k+7:8k]; field_word includes the byte being accepted now.
        field_word   = word_q | (XLEN'(in_data) << {byte_cnt_q, 3'b000});
        low_bits_set = |(field_word & XLEN'(L - 1));

        if (accept) begin
            byte_cnt_d = field_done ? '0 : byte_cnt_q + CW'(1);
            word_d     = field_done ? '0 : field_word;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = sum_q + in_data;
`endif
        end

        unique case (state_q)
            S_ENTRY: begin
                if (field_done) begin
                    entry_d = field_word;
                    state_d = S_SEG_ADDR;
                end
            end
            S_SEG_ADDR: begin
                if (field_done) begin
                    if (low_bits_set) begin
                        state_d = S_ERROR;
                    end else begin
                        ptr_d   = MEM_ADDR_BITS'(field_word >> LB);
                        state_d = S_SEG_SIZE;
                    end
                end
            end
            S_SEG_SIZE: begin
                if (field_done) begin
                    if (field_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_START;
`endif
                    end else if (seg_q == SCW'(MAX_SEGMENTS)) begin
                        state_d = S_ERROR;
                    end else begin
                        // Exact ceil(SIZE/L) without an overflowing add near the top of the range.
                        remain_d = (field_word >> LB) + XLEN'(low_bits_set);
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (field_done) begin
                    addr_d  = ptr_q;
                    wdata_d = field_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ptr_d    = ptr_q + MEM_ADDR_BITS'(1);
                remain_d = remain_q - XLEN'(1);
                if (remain_q == XLEN'(1)) begin
                    seg_d   = seg_q + SCW'(1);
                    state_d = S_SEG_ADDR;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = ((sum_q + in_data) == 8'd0) ? S_START : S_ERROR;
                end
            end
`endif
            S_START: state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ENTRY;
            byte_cnt_q <= '0;
            word_q     <= '0;
            entry_q    <= '0;
            ptr_q      <= '0;
            remain_q   <= '0;
            seg_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            entry_q    <= entry_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            seg_q      <= seg_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Address/data are registered so they hold their last written values outside WRITE.
    assign ocd_write_enable = (state_q == S_WRITE);
    assign ocd_rw_addr      = addr_q;
    assign ocd_write_word   = wdata_q;
    assign start            = (state_q == S_START);
    assign start_address    = entry_q;
    assign load_done        = (state_q == S_DONE);
    assign load_error       = (state_q == S_ERROR);
    assign seg_count        = seg_q;

endmodule

// File: tb/tb_ocd_stream_loader.sv
// Self-checking bench for ocd_stream_loader: directed vector table, corner sequences, and random images
// checked against a segment-level reference model; checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_ocd_stream_loader;
  localparam int XW   = 32;
  localparam int AW   = 16;
  localparam int MAXS = 2;
  localparam int SCW  = $clog2(MAXS + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_ready;
  logic           ocd_write_enable;
  logic [AW-1:0]  ocd_rw_addr;
  logic [XW-1:0]  ocd_write_word;
  logic           start;
  logic [XW-1:0]  start_address;
  logic           load_done;
  logic           load_error;
  logic [SCW-1:0] seg_count;

  ocd_stream_loader #(.XLEN(XW), .MEM_ADDR_BITS(AW), .MAX_SEGMENTS(MAXS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ocd_write_enable(ocd_write_enable), .ocd_rw_addr(ocd_rw_addr), .ocd_write_word(ocd_write_word),
    .start(start), .start_address(start_address), .load_done(load_done),
    .load_error(load_error), .seg_count(seg_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- state for model and scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0]       stream_q[$];
  logic [31:0]      sv_q[$];
  logic [31:0]      ss_q[$];
  logic [7:0]       sd_q[$];
  logic [AW+XW-1:0] exp_q[$];
  logic [AW+XW-1:0] got_q[$];
  logic [31:0]      exp_start_addr;
  bit               exp_err;
  bit               exp_done;
  int               exp_seg;
  int               start_cnt = 0;
  int               collide = 0;

  typedef struct {
    logic [31:0] entry;
    logic [31:0] vaddr;
    logic [31:0] size;
    logic [63:0] data;
    int          n_wr;
    logic [15:0] a0;
    logic [31:0] w0;
    logic [15:0] a1;
    logic [31:0] w1;
    bit          err;
    int          seg;
  } vec_t;

  vec_t vecs[4];

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (ocd_write_enable) got_q.push_back({ocd_rw_addr, ocd_write_word});
      if (start) start_cnt++;
      if (start && ocd_write_enable) collide++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stream_q.push_back(w[8*k +: 8]);
  endtask

  task automatic build_model(input logic [31:0] entry, input bit bad_cks);
    int          di;
    int          nw;
    logic [31:0] word;
    logic [31:0] wa;
    logic [7:0]  sum;
    logic [7:0]  cks;
    stream_q.delete();
    exp_q.delete();
    exp_err = 0;
    exp_done = 0;
    exp_seg = 0;
    exp_start_addr = entry;
    di = 0;
    push_word(entry);
    for (int s = 0; s < sv_q.size(); s++) begin
      push_word(sv_q[s]);
      if (sv_q[s] % 4 != 0) begin
        exp_err = 1;
        return;
      end
      push_word(ss_q[s]);
      if (ss_q[s] == 0) begin
        sum = 8'h00;
        cks = 8'h00;
        foreach (stream_q[i]) sum = sum + stream_q[i];
        cks = 8'h00 - sum;
        if (bad_cks) cks = cks + 8'h01;
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(cks);
        if (bad_cks) begin
          exp_err = 1;
          return;
        end
`endif
        exp_done = 1;
        return;
      end
      if (exp_seg == MAXS) begin
        exp_err = 1;
        return;
      end
      nw = int'((ss_q[s] + 32'd3) / 32'd4);
      for (int w = 0; w < nw; w++) begin
        word = {sd_q[di+3], sd_q[di+2], sd_q[di+1], sd_q[di]};
        push_word(word);
        wa = (sv_q[s] / 32'd4) + 32'(w);
        exp_q.push_back({wa[15:0], word});
        di += 4;
      end
      exp_seg++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_we", 64'(ocd_write_enable), 64'd0);
    check("rst_addr", 64'(ocd_rw_addr), 64'd0);
    check("rst_word", 64'(ocd_write_word), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_start_addr", 64'(start_address), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_error), 64'd0);
    check("rst_seg", 64'(seg_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Each byte is presented at a falling edge; it is accepted at the next rising edge if in_ready is high.
  task automatic send_stream(input bit gap_mode, input int limit, output bit stalled);
    int n;
    stalled = 0;
    for (int i = 0; i < limit; i++) begin
      if (gap_mode) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = stream_q[i];
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        stalled = 1;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit gap_mode);
    int got_base;
    int start_base;
    int col_base;
    int n;
    bit stalled;
    do_reset();
    got_base = got_q.size();
    start_base = start_cnt;
    col_base = collide;
    send_stream(gap_mode, stream_q.size(), stalled);
    repeat (4) @(negedge clk);
    check({tag, "_stall"}, 64'(stalled), 64'd0);
    n = got_q.size() - got_base;
    check({tag, "_wr_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check({tag, "_wr"}, 64'(got_q[got_base+i]), 64'(exp_q[i]));
    check({tag, "_start_pulses"}, 64'(start_cnt - start_base), 64'(exp_done));
    check({tag, "_start_address"}, 64'(start_address), 64'(exp_start_addr));
    check({tag, "_load_done"}, 64'(load_done), 64'(exp_done));
    check({tag, "_load_error"}, 64'(load_error), 64'(exp_err));
    check({tag, "_seg_count"}, 64'(seg_count), 64'(exp_seg));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_collide"}, 64'(collide - col_base), 64'd0);
    if (exp_q.size() > 0)
      check({tag, "_hold"}, 64'({ocd_rw_addr, ocd_write_word}), 64'(exp_q[exp_q.size()-1]));
  endtask

  task automatic load_vec(input vec_t v);
    sv_q = '{v.vaddr, 32'h0000_0000};
    ss_q = '{v.size, 32'd0};
    sd_q.delete();
    for (int k = 0; k < 8; k++) sd_q.push_back(v.data[8*k +: 8]);
    build_model(v.entry, 1'b0);
    // Directed vectors use the table's own hand-derived expectations.
    exp_q.delete();
    if (v.n_wr > 0) exp_q.push_back({v.a0, v.w0});
    if (v.n_wr > 1) exp_q.push_back({v.a1, v.w1});
    exp_err = v.err;
    exp_done = !v.err;
    exp_seg = v.seg;
    exp_start_addr = v.entry;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit          st;
    int          nseg;
    int          sz;
    logic [31:0] va;

    vecs[0] = '{32'h8000_0000, 32'h8000_0000, 32'd8, 64'h0010_0093_0000_0013,
                2, 16'h0000, 32'h0000_0013, 16'h0001, 32'h0010_0093, 1'b0, 1};
    vecs[1] = '{32'h0000_0100, 32'h0000_0040, 32'd5, 64'h0807_0605_0403_0201,
                2, 16'h0010, 32'h0403_0201, 16'h0011, 32'h0807_0605, 1'b0, 1};
    vecs[2] = '{32'h0040_0000, 32'h8000_0002, 32'd4, 64'h0,
                0, 16'h0000, 32'h0, 16'h0000, 32'h0, 1'b1, 0};
    vecs[3] = '{32'h0000_0000, 32'h0003_FFFC, 32'd8, 64'h8877_6655_4433_2211,
                2, 16'hFFFF, 32'h4433_2211, 16'h0000, 32'h8877_6655, 1'b0, 1};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      load_vec(vecs[i]);
      run_check($sformatf("vec%0d", i), 1'b0);
    end

    // Valid toggling every other cycle must give the same write sequence.
    load_vec(vecs[0]);
    run_check("toggle", 1'b1);

    // Third non-empty segment exceeds the segment limit.
    sv_q = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0};
    ss_q = '{32'd4, 32'd4, 32'd4, 32'd0};
    sd_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c};
    build_model(32'h0000_1234, 1'b0);
    run_check("limit", 1'b0);
    check("limit_seg_const", 64'(seg_count), 64'd2);
    check("limit_err_const", 64'(load_error), 64'd1);

    // Reset after two data bytes: no strobe, everything cleared, then a fresh parse succeeds.
    load_vec(vecs[0]);
    do_reset();
    begin
      int base;
      base = got_q.size();
      send_stream(1'b0, 14, st);
      repeat (2) @(negedge clk);
      check("mid_no_strobe", 64'(got_q.size() - base), 64'd0);
      check("mid_ready", 64'(in_ready), 64'd1);
      do_reset();
      repeat (2) @(negedge clk);
      check("mid_after_no_strobe", 64'(got_q.size() - base), 64'd0);
    end
    run_check("mid_fresh", 1'b0);

    // Random images against the reference model.
    for (int it = 0; it < 30; it++) begin
      sv_q.delete();
      ss_q.delete();
      sd_q.delete();
      nseg = $urandom_range(0, (it % 5 == 0) ? MAXS + 1 : MAXS);
      for (int s = 0; s < nseg; s++) begin
        va = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) va = va | 32'($urandom_range(1, 3));
        sz = $urandom_range(1, 20);
        sv_q.push_back(va);
        ss_q.push_back(32'(sz));
        for (int b = 0; b < ((sz + 3) / 4) * 4; b++) sd_q.push_back(8'($urandom));
      end
      sv_q.push_back($urandom & 32'hFFFF_FFFC);
      ss_q.push_back(32'd0);
      build_model($urandom, 1'b0);
      run_check($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
    end

`ifdef LOADER_CHECKSUM_EN
    sv_q = '{32'h0000_0040, 32'h0};
    ss_q = '{32'd6, 32'd0};
    sd_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    build_model(32'h8000_0000, 1'b0);
    run_check("cks_good", 1'b0);
    build_model(32'h8000_0000, 1'b1);
    run_check("cks_bad", 1'b0);
    check("cks_bad_no_start", 64'(load_done), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
